// File: rtl/btb_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : btb_next_pc
// Description : Next-PC generator for the RV32 fetch stage. Predicts the fetch
//               target from a direct-mapped BTB with 2-bit saturating
//               counters, redirects and flushes on EX-stage mispredictions,
//               and keeps branch / mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_next_pc #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  input  logic        hazard_stall,
  input  logic        ex_valid,
  input  logic        ex_is_cf,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic [31:0] ex_pred_next,
  output logic [31:0] next_pc,
  output logic        pc_stall,
  output logic        pred_taken,
  output logic        flush,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [1:0] C_CTR_MIN    = 2'b00;
  localparam logic [1:0] C_CTR_WEAK_N = 2'b01;
  localparam logic [1:0] C_CTR_WEAK_T = 2'b10;
  localparam logic [1:0] C_CTR_MAX    = 2'b11;

  // BTB storage; tag and target carry no reset because valid gates them
  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0] w_fetch_idx;
  logic [TAG_W-1:0] w_fetch_tag;
  logic             w_hit;
  logic             w_pred_taken;
  logic [31:0]      w_actual_next;
  logic             w_redirect;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic             w_update;

  assign w_fetch_idx = current_pc[1+IDX_W:2];
  assign w_fetch_tag = current_pc[31:2+IDX_W];
  assign w_upd_idx   = ex_pc[1+IDX_W:2];
  assign w_upd_tag   = ex_pc[31:2+IDX_W];
  assign w_update    = ex_valid && ex_is_cf;

  // Lookup and resolution: prediction for the fetch PC and redirect check for EX
  always_comb begin
    w_hit         = valid_q[w_fetch_idx] && (tag_q[w_fetch_idx] == w_fetch_tag);
    w_pred_taken  = w_hit && ctr_q[w_fetch_idx][1];
    w_actual_next = ex_taken ? ex_target : (ex_pc + 32'd4);
    // Checked for every real instruction so an aliased false hit on a
    // non-control instruction is also corrected.
    w_redirect    = ex_valid && (w_actual_next != ex_pred_next);
    w_upd_hit     = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == w_upd_tag);
  end

  // Output selection: redirect beats prediction beats sequential fetch
  always_comb begin
    next_pc    = current_pc + 32'd4;
    pred_taken = w_pred_taken;
    flush      = w_redirect;
    pc_stall   = hazard_stall && !w_redirect;
    if (w_redirect) begin
      next_pc = w_actual_next;
    end else if (w_pred_taken) begin
      next_pc = target_q[w_fetch_idx];
    end
    if (reset) begin
      next_pc    = 32'd0;
      pred_taken = 1'b0;
      flush      = 1'b0;
      pc_stall   = 1'b0;
    end
  end

  // Next-state of the table and statistics from the resolved EX instruction
  always_comb begin
    valid_d            = valid_q;
    tag_d              = tag_q;
    target_d           = target_q;
    ctr_d              = ctr_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q + 32'(w_redirect);
    if (w_update) begin
      branch_count_d = branch_count_q + 32'd1;
      if (!w_upd_hit) begin
        valid_d[w_upd_idx]  = 1'b1;
        tag_d[w_upd_idx]    = w_upd_tag;
        target_d[w_upd_idx] = ex_target;
        ctr_d[w_upd_idx]    = ex_taken ? C_CTR_WEAK_T : C_CTR_WEAK_N;
      end else if (ex_taken) begin
        target_d[w_upd_idx] = ex_target;
        if (ctr_q[w_upd_idx] != C_CTR_MAX) begin
          ctr_d[w_upd_idx] = ctr_q[w_upd_idx] + 2'd1;
        end
      end else if (ctr_q[w_upd_idx] != C_CTR_MIN) begin
        ctr_d[w_upd_idx] = ctr_q[w_upd_idx] - 2'd1;
      end
    end
  end

  // Resettable state: valid bits, counters and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= C_CTR_MIN;
      end
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      valid_q            <= valid_d;
      ctr_q              <= ctr_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Tag and target payload; a reset edge still suppresses any pending write
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
`default_nettype wire

// File: tb/tb_btb_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_next_pc
// Description : Self-checking bench for btb_next_pc: directed scenarios and
//               randomized traffic compared against a behavioural BTB model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_next_pc;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_pc;
  logic        hazard_stall;
  logic        ex_valid;
  logic        ex_is_cf;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] ex_pred_next;
  logic [31:0] next_pc;
  logic        pc_stall;
  logic        pred_taken;
  logic        flush;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  always #5 clk = ~clk;

  btb_next_pc #(.ENTRIES(ENTRIES)) dut (
    .clk              (clk),
    .reset            (reset),
    .current_pc       (current_pc),
    .hazard_stall     (hazard_stall),
    .ex_valid         (ex_valid),
    .ex_is_cf         (ex_is_cf),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_next     (ex_pred_next),
    .next_pc          (next_pc),
    .pc_stall         (pc_stall),
    .pred_taken       (pred_taken),
    .flush            (flush),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: one record per slot, counter held as a plain integer
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (2 + IDX_W);
  endfunction

  function automatic logic [31:0] actual_of();
    return ex_taken ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic model_outputs(output logic [31:0] e_next, output logic e_stall,
                               output logic e_pt, output logic e_flush);
    int  s;
    bit  redir;
    s      = slot_of(current_pc);
    e_pt   = m_valid[s] && (m_tag[s] == tag_of(current_pc)) && (m_ctr[s] >= 2);
    redir  = ex_valid && (actual_of() != ex_pred_next);
    e_flush = redir;
    e_stall = hazard_stall && !redir;
    if (redir)     e_next = actual_of();
    else if (e_pt) e_next = m_target[s];
    else           e_next = current_pc + 32'd4;
    if (reset) begin
      e_next = 0; e_stall = 0; e_pt = 0; e_flush = 0;
    end
  endtask

  task automatic model_edge();
    int s;
    bit hit;
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0;
        m_ctr[i]   = 0;
      end
      m_bc = 0;
      m_mc = 0;
      return;
    end
    if (ex_valid && (actual_of() != ex_pred_next)) m_mc = m_mc + 1;
    if (ex_valid && ex_is_cf) begin
      m_bc = m_bc + 1;
      s    = slot_of(ex_pc);
      hit  = m_valid[s] && (m_tag[s] == tag_of(ex_pc));
      if (!hit) begin
        m_valid[s]  = 1;
        m_tag[s]    = tag_of(ex_pc);
        m_target[s] = ex_target;
        m_ctr[s]    = ex_taken ? 2 : 1;
      end else if (ex_taken) begin
        m_target[s] = ex_target;
        m_ctr[s]    = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
      end else begin
        m_ctr[s]    = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
      end
    end
  endtask

  // Let inputs settle, then compare every output with the model
  task automatic settle();
    logic [31:0] e_next;
    logic        e_stall, e_pt, e_flush;
    #1;
    model_outputs(e_next, e_stall, e_pt, e_flush);
    check("next_pc", next_pc, e_next);
    check("pc_stall", 32'(pc_stall), 32'(e_stall));
    check("pred_taken", 32'(pred_taken), 32'(e_pt));
    check("flush", 32'(flush), 32'(e_flush));
    check("branch_count", branch_count, m_bc);
    check("mispredict_count", mispredict_count, m_mc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_ex(input logic v, input logic cf, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt, input logic [31:0] pred);
    ex_valid = v; ex_is_cf = cf; ex_pc = pc;
    ex_taken = tk; ex_target = tgt; ex_pred_next = pred;
  endtask

  task automatic no_ex();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] pool_pc();
    logic [31:0] p;
    if ($urandom_range(0, 15) == 0) begin
      p = $urandom();
      p[1:0] = 2'b00;
    end else begin
      p = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
    end
    return p;
  endfunction

  initial begin
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 0;
    end
    m_bc = 0; m_mc = 0;

    // Reset: outputs forced low
    reset = 1; hazard_stall = 0; current_pc = 32'h100; no_ex();
    settle();
    check("rst_next_pc", next_pc, 32'h0);
    tick();
    settle();
    tick();

    // Cold fetch
    reset = 0;
    settle();
    check("cold_next_pc", next_pc, 32'h104);
    check("cold_pred", 32'(pred_taken), 32'h0);
    check("cold_bc", branch_count, 32'h0);
    tick();

    // Allocate with a mispredicted taken branch
    current_pc = 32'h200;
    set_ex(1, 1, 32'h100, 1, 32'h80, 32'h104);
    settle();
    check("alloc_flush", 32'(flush), 32'h1);
    check("alloc_next_pc", next_pc, 32'h80);
    tick();

    no_ex(); current_pc = 32'h100;
    settle();
    check("alloc_mc", mispredict_count, 32'h1);
    check("alloc_pred", 32'(pred_taken), 32'h1);
    check("alloc_predict_pc", next_pc, 32'h80);
    tick();

    // Hysteresis: taken -> 11, not-taken -> 10 still predicts, again -> 01
    set_ex(1, 1, 32'h100, 1, 32'h80, 32'h80);
    settle(); tick();
    set_ex(1, 1, 32'h100, 0, 32'h80, 32'h80);
    settle();
    check("nt_redirect", next_pc, 32'h104);
    tick();
    no_ex();
    settle();
    check("hyst_still_pred", next_pc, 32'h80);
    tick();
    set_ex(1, 1, 32'h100, 0, 32'h80, 32'h80);
    settle(); tick();
    no_ex();
    settle();
    check("hyst_flip_next", next_pc, 32'h104);
    tick();

    // Taken three times saturates; one not-taken still predicts taken
    for (int k = 0; k < 3; k++) begin
      set_ex(1, 1, 32'h100, 1, 32'h80, 32'h80);
      settle(); tick();
    end
    set_ex(1, 1, 32'h100, 0, 32'h80, 32'h80);
    settle(); tick();
    no_ex();
    settle();
    check("sat_pred", 32'(pred_taken), 32'h1);
    tick();

    // Aliasing: same index, different tag misses
    current_pc = 32'h140;
    settle();
    check("alias_pred", 32'(pred_taken), 32'h0);
    check("alias_next", next_pc, 32'h144);
    tick();

    // Non-control instruction fetched down a false-hit path is corrected
    current_pc = 32'h200;
    set_ex(1, 0, 32'h100, 0, 32'h0, 32'h80);
    settle();
    check("noncf_flush", 32'(flush), 32'h1);
    check("noncf_next", next_pc, 32'h104);
    tick();
    no_ex(); current_pc = 32'h100;
    settle(); tick();

    // Stall alone, then stall with a mispredict
    hazard_stall = 1;
    settle();
    check("stall_only", 32'(pc_stall), 32'h1);
    tick();
    set_ex(1, 1, 32'h184, 1, 32'h300, 32'h188);
    settle();
    check("stall_redir_stall", 32'(pc_stall), 32'h0);
    check("stall_redir_flush", 32'(flush), 32'h1);
    check("stall_redir_next", next_pc, 32'h300);
    tick();
    hazard_stall = 0; no_ex();

    // PC wrap on a miss
    current_pc = 32'hFFFF_FFFC;
    settle();
    check("wrap_next", next_pc, 32'h0);
    tick();

    // Same-cycle lookup and update read the old entry
    current_pc = 32'h300;
    set_ex(1, 1, 32'h300, 1, 32'h400, 32'h304);
    settle();
    check("same_cycle_pred", 32'(pred_taken), 32'h0);
    tick();
    no_ex();
    settle();
    check("after_update_pred", 32'(pred_taken), 32'h1);
    check("after_update_next", next_pc, 32'h400);
    tick();

    // Mid-run reset drops the pending update and clears statistics
    reset = 1;
    set_ex(1, 1, 32'h500, 1, 32'h600, 32'h504);
    settle();
    check("midrst_flush", 32'(flush), 32'h0);
    tick();
    reset = 0; no_ex(); current_pc = 32'h500;
    settle();
    check("midrst_bc", branch_count, 32'h0);
    check("midrst_mc", mispredict_count, 32'h0);
    check("midrst_next", next_pc, 32'h504);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset        = ($urandom_range(0, 63) == 0);
      hazard_stall = $urandom_range(0, 3) == 0;
      current_pc   = pool_pc();
      ex_valid     = $urandom_range(0, 3) != 0;
      ex_is_cf     = $urandom_range(0, 3) != 0;
      ex_pc        = pool_pc();
      ex_taken     = $urandom_range(0, 1) == 1;
      ex_target    = pool_pc();
      ex_pred_next = ($urandom_range(0, 1) == 1) ? actual_of() : pool_pc();
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
